// File: rtl/bt_pipe_pkg.sv
// Shared constants for the block pipe FIFO: width defaults, pointer sizing
// and the bit layout of the packed error-status wire.
package bt_pipe_pkg;

   localparam int DATA_W_DEF      = 32;
   localparam int BLOCK_WORDS_DEF = 4;

   // Status wire-out layout: {misalign, underflow, overflow} at bits [2:0].
   localparam int ERR_OVERFLOW_BIT  = 0;
   localparam int ERR_UNDERFLOW_BIT = 1;
   localparam int ERR_MISALIGN_BIT  = 2;

   // One extra bit above the address gives the wrap bit for full/empty.
   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic logic [2:0] pack_status(input logic overflow,
                                              input logic underflow,
                                              input logic misalign);
      logic [2:0] s;
      s = '0;
      s[ERR_OVERFLOW_BIT]  = overflow;
      s[ERR_UNDERFLOW_BIT] = underflow;
      s[ERR_MISALIGN_BIT]  = misalign;
      return s;
   endfunction

endpackage

// File: rtl/bt_fifo_mem.sv
// Simple dual-port RAM: synchronous write, registered read that holds its
// value when no read is requested.
module bt_fifo_mem #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 64,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              wr_en_i,
   input  logic [AW-1:0]     wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              rd_en_i,
   input  logic [AW-1:0]     rd_addr_i,
   output logic [DATA_W-1:0] rd_data_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rd_data_q;

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rd_data_q <= '0;
      end else if (rd_en_i) begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/bt_block_fifo.sv
// Block-granular FIFO between a block-throttled pipe-in and pipe-out endpoint,
// with block-level ready decoding and sticky protocol-error flags.
module bt_block_fifo
   import bt_pipe_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int DEPTH       = 64,
   parameter int BLOCK_WORDS = BLOCK_WORDS_DEF
) (
   input  logic                   okClk,
   input  logic                   rstn,
   input  logic                   flush,
   input  logic [DATA_W-1:0]      in_data,
   input  logic                   in_write,
   input  logic                   in_blockstrobe,
   output logic                   in_ready,
   input  logic                   out_read,
   input  logic                   out_blockstrobe,
   output logic [DATA_W-1:0]      out_data,
   output logic                   out_ready,
   output logic [$clog2(DEPTH):0] level,
   output logic                   overflow,
   output logic                   underflow,
   output logic                   misalign
);

   localparam int PW = ptr_width(DEPTH);
   localparam int AW = PW - 1;
   localparam int CW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
   localparam logic [PW-1:0] DEPTH_P  = PW'(DEPTH);
   localparam logic [PW-1:0] BLOCK_P  = PW'(BLOCK_WORDS);
   localparam logic [CW-1:0] CNT_LAST = CW'(BLOCK_WORDS - 1);

   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;
   logic          ovf_q, ovf_d, udf_q, udf_d, mis_q, mis_d;
   logic [PW-1:0] level_w, free_w;
   logic          full_w, empty_w, wr_en, rd_en;

   // A word moves on the write side when in_write is high and the FIFO is
   // not full, and on the read side when out_read is high and it is not
   // empty; in_ready/out_ready are advisory whole-block grants only.
   assign level_w = wr_ptr_q - rd_ptr_q;
   assign free_w  = DEPTH_P - level_w;
   assign full_w  = (level_w == DEPTH_P);
   assign empty_w = (level_w == '0);
   assign wr_en   = in_write && !full_w && !flush;
   assign rd_en   = out_read && !empty_w && !flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      wcnt_d   = wcnt_q;
      rcnt_d   = rcnt_q;
      ovf_d    = ovf_q;
      udf_d    = udf_q;
      mis_d    = mis_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         wcnt_d   = '0;
         rcnt_d   = '0;
         ovf_d    = 1'b0;
         udf_d    = 1'b0;
         mis_d    = 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            wcnt_d   = (wcnt_q == CNT_LAST) ? '0 : wcnt_q + 1'b1;
         end
         if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            rcnt_d   = (rcnt_q == CNT_LAST) ? '0 : rcnt_q + 1'b1;
         end
         if (in_write && full_w)                 ovf_d = 1'b1;
         if (out_read && empty_w)                udf_d = 1'b1;
         if (in_blockstrobe && (wcnt_q != '0))   mis_d = 1'b1;
         if (out_blockstrobe && (rcnt_q != '0))  mis_d = 1'b1;
      end
   end

   always_ff @(posedge okClk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         wcnt_q   <= '0;
         rcnt_q   <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
         mis_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         wcnt_q   <= wcnt_d;
         rcnt_q   <= rcnt_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
         mis_q    <= mis_d;
      end
   end

   bt_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk_i     (okClk),
      .rst_n_i   (rstn),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_ptr_q[AW-1:0]),
      .wr_data_i (in_data),
      .rd_en_i   (rd_en),
      .rd_addr_i (rd_ptr_q[AW-1:0]),
      .rd_data_o (out_data)
   );

   assign level     = level_w;
   assign in_ready  = (free_w >= BLOCK_P);
   assign out_ready = (level_w >= BLOCK_P);
   assign overflow  = ovf_q;
   assign underflow = udf_q;
   assign misalign  = mis_q;

endmodule

// File: tb/tb_bt_block_fifo.sv
// Directed bench for bt_block_fifo: reset, block transfer, fill/overflow,
// concurrent access, wrap streaming, underflow, misalign, flush and reset.
module tb_bt_block_fifo;

  logic        okClk;
  logic        rstn;
  logic        flush;
  logic [31:0] in_data;
  logic        in_write;
  logic        in_blockstrobe;
  logic        in_ready;
  logic        out_read;
  logic        out_blockstrobe;
  logic [31:0] out_data;
  logic        out_ready;
  logic [6:0]  level;
  logic        overflow;
  logic        underflow;
  logic        misalign;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_out;

  bt_block_fifo #(.DATA_W(32), .DEPTH(64), .BLOCK_WORDS(4)) dut (
    .okClk           (okClk),
    .rstn            (rstn),
    .flush           (flush),
    .in_data         (in_data),
    .in_write        (in_write),
    .in_blockstrobe  (in_blockstrobe),
    .in_ready        (in_ready),
    .out_read        (out_read),
    .out_blockstrobe (out_blockstrobe),
    .out_data        (out_data),
    .out_ready       (out_ready),
    .level           (level),
    .overflow        (overflow),
    .underflow       (underflow),
    .misalign        (misalign)
  );

  // clock / reset
  initial begin
    okClk = 1'b0;
    forever #5 okClk = ~okClk;
  end

  // inputs change and outputs are sampled 1 ns after the rising edge
  task automatic tick();
    @(posedge okClk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_level"}, 32'(level), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_ready"}, 32'(out_ready), 32'd0);
    chk({tag, "_flags"}, 32'({misalign, underflow, overflow}), 32'd0);
  endtask

  // driver tasks
  task automatic wr(input logic [31:0] d, input logic strobe);
    in_data = d;
    in_write = 1'b1;
    in_blockstrobe = strobe;
    tick();
    in_write = 1'b0;
    in_blockstrobe = 1'b0;
    exp_q.push_back(d);
  endtask

  task automatic rd_chk(input string tag, input logic strobe);
    logic [31:0] e;
    out_read = 1'b1;
    out_blockstrobe = strobe;
    tick();
    out_read = 1'b0;
    out_blockstrobe = 1'b0;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    chk(tag, out_data, e);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    rstn = 1'b0;
    flush = 1'b0;
    in_data = '0;
    in_write = 1'b0;
    in_blockstrobe = 1'b0;
    out_read = 1'b0;
    out_blockstrobe = 1'b0;
    #12;
    chk_idle("reset");
    chk("reset_out_data", out_data, 32'h0);
    rstn = 1'b1;
    tick();
    tick();
    chk_idle("idle");

    // one aligned block through
    wr(32'h1111_1111, 1'b1);
    wr(32'h2222_2222, 1'b0);
    wr(32'h3333_3333, 1'b0);
    chk("blk_out_ready_3", 32'(out_ready), 32'd0);
    wr(32'h4444_4444, 1'b0);
    chk("blk_level", 32'(level), 32'd4);
    chk("blk_out_ready", 32'(out_ready), 32'd1);
    rd_chk("blk_rd0", 1'b1);
    rd_chk("blk_rd1", 1'b0);
    rd_chk("blk_rd2", 1'b0);
    rd_chk("blk_rd3", 1'b0);
    chk("blk_last", out_data, 32'h4444_4444);
    chk("blk_level_end", 32'(level), 32'd0);
    chk("blk_misalign", 32'(misalign), 32'd0);

    // fill to 64, in_ready threshold, overflow
    for (int i = 0; i < 64; i++) begin
      wr(32'hA000_0000 + 32'(i), 1'b0);
      if (i == 59) chk("fill_in_ready_60", 32'(in_ready), 32'd1);
      if (i == 60) chk("fill_in_ready_61", 32'(in_ready), 32'd0);
    end
    chk("fill_level", 32'(level), 32'd64);
    in_data = 32'hBAD0_BAD0;
    in_write = 1'b1;
    tick();
    in_write = 1'b0;
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_level", 32'(level), 32'd64);
    chk("ovf_out_ready", 32'(out_ready), 32'd1);
    for (int i = 0; i < 64; i++) rd_chk("fill_rd", 1'b0);
    chk("fill_level_end", 32'(level), 32'd0);
    chk("fill_ovf_sticky", 32'(overflow), 32'd1);
    do_flush();
    chk_idle("flush1");

    // concurrent read/write at level 10
    for (int i = 0; i < 10; i++) wr(32'hC000_0000 + 32'(i), 1'b0);
    chk("rw_level_pre", 32'(level), 32'd10);
    for (int i = 0; i < 5; i++) begin
      logic [31:0] e;
      in_data = 32'hC100_0000 + 32'(i);
      in_write = 1'b1;
      out_read = 1'b1;
      exp_q.push_back(in_data);
      tick();
      e = exp_q.pop_front();
      chk("rw_data", out_data, e);
      chk("rw_level", 32'(level), 32'd10);
    end
    in_write = 1'b0;
    out_read = 1'b0;
    for (int i = 0; i < 10; i++) rd_chk("rw_drain", 1'b0);
    chk("rw_level_end", 32'(level), 32'd0);
    do_flush();

    // streaming with read lagging 8 words, covers pointer wrap
    begin
      int nrd;
      nrd = 0;
      for (int i = 0; i < 208; i++) begin
        logic rd_now;
        logic [31:0] e;
        in_write = (i < 200);
        in_blockstrobe = (i < 200) && (i % 4 == 0);
        in_data = 32'(i) * 32'h0101_0101 + 32'h5A;
        if (i < 200) exp_q.push_back(in_data);
        rd_now = (i >= 8) && (nrd < 200);
        out_read = rd_now;
        out_blockstrobe = rd_now && (nrd % 4 == 0);
        tick();
        if (rd_now) begin
          e = exp_q.pop_front();
          chk("stream_data", out_data, e);
          nrd++;
        end
      end
      in_write = 1'b0;
      in_blockstrobe = 1'b0;
      out_read = 1'b0;
      out_blockstrobe = 1'b0;
      chk("stream_nrd", 32'(nrd), 32'd200);
    end
    chk("stream_level", 32'(level), 32'd0);
    chk("stream_flags", 32'({misalign, underflow, overflow}), 32'd0);

    // write in one cycle, read it the next
    wr(32'h7777_0001, 1'b0);
    rd_chk("wr2rd", 1'b0);
    last_out = out_data;

    // underflow holds out_data
    out_read = 1'b1;
    tick();
    out_read = 1'b0;
    chk("udf_flag", 32'(underflow), 32'd1);
    chk("udf_hold", out_data, 32'h7777_0001);
    chk("udf_level", 32'(level), 32'd0);

    // misalign, then flush
    do_flush();
    chk("flush2_udf", 32'(underflow), 32'd0);
    wr(32'hE000_0000, 1'b1);
    wr(32'hE000_0001, 1'b0);
    chk("mis_pre", 32'(misalign), 32'd0);
    in_blockstrobe = 1'b1;
    tick();
    in_blockstrobe = 1'b0;
    chk("mis_flag", 32'(misalign), 32'd1);
    chk("mis_level", 32'(level), 32'd2);
    do_flush();
    chk_idle("flush3");
    chk("flush_out_hold", out_data, last_out);

    // async reset mid-stream
    wr(32'hF000_0000, 1'b0);
    wr(32'hF000_0001, 1'b0);
    in_blockstrobe = 1'b1;
    tick();
    in_blockstrobe = 1'b0;
    rd_chk("pre_rst_rd", 1'b0);
    chk("pre_rst_mis", 32'(misalign), 32'd1);
    @(negedge okClk);
    #2;
    rstn = 1'b0;
    #1;
    chk_idle("async_rst");
    chk("async_rst_out", out_data, 32'h0);
    #5;
    rstn = 1'b1;
    exp_q.delete();
    tick();
    chk_idle("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bt_block_fifo.md
# bt_block_fifo

Block-granular FIFO between an okBTPipeIn endpoint (write side) and an okBTPipeOut endpoint (read side), all in the okClk domain. It replaces fixed-size register stores so the host can stream any number of blocks. Flow control is expressed only through the endpoints' ep_ready inputs: whole-block space on the write side, and whole-block data on the read side. Sticky error flags report protocol violations to a status wire.

## Interface
- DATA_W, 32: word width, matching the pipe bus.
- DEPTH, 64: FIFO depth in words; power of two, at least 2*BLOCK_WORDS.
- BLOCK_WORDS, 4: words per host block (block size in bytes / 4); power of two.

- okClk  in  1  sole clock, host interface clock.
- rstn  in  1  reset, asynchronous assert, active-low.
- flush  in  1  synchronous clear of contents and flags.
- in_data  in  DATA_W  from okBTPipeIn ep_dataout.
- in_write  in  1  from okBTPipeIn ep_write.
- in_blockstrobe  in  1  from okBTPipeIn ep_blockstrobe.
- in_ready  out  1  to okBTPipeIn ep_ready.
- out_read  in  1  from okBTPipeOut ep_read.
- out_blockstrobe  in  1  from okBTPipeOut ep_blockstrobe.
- out_data  out  DATA_W  to okBTPipeOut ep_datain, registered.
- out_ready  out  1  to okBTPipeOut ep_ready.
- level  out  $clog2(DEPTH)+1  words currently stored.
- overflow, underflow, misalign  out  1 each  sticky error flags.

## Operation
- Pointers wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits wide, with the MSB used as the wrap bit.
  - level = wr_ptr - rd_ptr, mod 2^(width).
  - full when level == DEPTH; empty when level == 0.
- Write:
  - If in_write and not full: store in_data at mem[wr_ptr], then increment wr_ptr.
  - If in_write while full: drop the word, leave wr_ptr unchanged, set overflow.
- Read:
  - If out_read and not empty: out_data <= mem[rd_ptr], then increment rd_ptr.
  - If out_read while empty: out_data holds, rd_ptr unchanged, set underflow.
- Simultaneous read and write are both honoured and level is unchanged.
  - With level 0, the read underflows; there is no write-to-read bypass.
  - With level DEPTH, the read frees no space for the same-cycle write, so the write overflows.
- Flow control:
  - in_ready = (DEPTH - level) >= BLOCK_WORDS.
  - out_ready = level >= BLOCK_WORDS.
  - Both are decoded from registered pointers and are never asserted mid-cycle from the current request.
- Block alignment:
  - A write-word counter runs mod BLOCK_WORDS and advances on every accepted write.
  - A read-word counter does the same on every accepted read.
  - If in_blockstrobe arrives with the write counter != 0, set misalign. Apply the same rule to out_blockstrobe and the read counter.
- flush:
  - Clears pointers, counters and all three flags.
  - out_data holds its value.
  - flush takes priority over same-cycle read and write.
- Flags are cleared only by rstn low or flush.

## Timing
- Reset values: out_data 0, level 0, in_ready 1, out_ready 0, overflow/underflow/misalign 0. Pointers and counters are 0.
- Read latency: out_data is valid 1 cycle after the out_read cycle, matching the okBTPipeOut ep_read-to-datain convention.
- Write-to-read: a word written in cycle N can be read from cycle N+1.
- Flag updates: level, in_ready and out_ready change 1 cycle after the accepted access.
- Reset or flush mid-block:
  - The next block is taken as a fresh block; the word counters restart at 0.
  - Host-side block loss is host policy.
- Depth margin: with DEPTH >= 2*BLOCK_WORDS, a block already granted by in_ready never overflows.

## Structure
- Shared package bt_pipe_pkg holds:
  - the DATA_W and BLOCK_WORDS defaults;
  - the pointer-width constant function;
  - the error-flag bit positions for packing {misalign, underflow, overflow} into a status wire-out at bits [2:0].
- One sub-module, bt_fifo_mem: simple dual-port RAM with synchronous write and registered read. Its registered read data is out_data, and it can infer distributed or block RAM.
- Pointer, counter, flag and ready logic live in bt_block_fifo.

## Test plan
- Reset, then idle: in_ready=1, out_ready=0, level=0, out_data=0, all flags 0.
- Write 4 words 0x11111111..0x44444444 with blockstrobe on the first:
  - level=4 and out_ready=1 on the next cycle.
  - 4 reads return the same words in order, each 1 cycle after its out_read.
  - level returns to 0 and misalign stays 0.
- Write 64 words: in_ready drops once level reaches 61. A 65th write sets overflow, level stays 64 and the stored data is unchanged.
- With level=10, assert read and write together for 5 cycles: level stays 10 throughout and the data order is preserved.
- Wrap and underflow:
  - Stream 200 words through in 4-word blocks with reads lagging by 8 words: output equals input, covering pointer wrap.
  - out_read at level 0: underflow=1, out_data holds its last value.
- Alignment and flush:
  - in_blockstrobe after 2 of 4 words sets misalign.
  - flush then gives level=0 and flags 0.
  - rstn low mid-stream gives all reset values immediately, without waiting for an okClk edge.
